// File: rtl/inst_mem_resp_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// the default NOP word and the address-to-index / legality helpers.
package inst_mem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST_WORD = 32'h0000_0013;

    // Word index relative to the memory base; the subtraction wraps on purpose.
    function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                  input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return {2'b00, off[31:2]};
    endfunction

    // True when the byte address is word-aligned and maps inside the array.
    function automatic logic addr_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] depth);
        logic [31:0] idx;
        idx = addr_to_index(addr, base);
        return (addr[1:0] == 2'b00) && (addr >= base) && (idx < depth);
    endfunction

endpackage

// File: rtl/inst_mem_resp_imem_array.sv
// Instruction word array: synchronous write port, combinational read port.
// The reader captures rd_data on a clock edge, so a write to the same word on
// that edge is not yet visible -- the capture sees the old word.
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Program-load write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: accepts a PC fetch over valid/ready, waits a
// fixed number of cycles, then presents the instruction until consumed.
module inst_mem_resp
    import inst_mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = NOP_INST_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_inst_o,
    output logic        rsp_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        busy_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];
    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    typedef logic [IDX_W-1:0] idx_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;

    logic [31:0] rd_addr;
    idx_t        rd_idx;
    logic        rd_ok;
    logic [31:0] rd_data;
    idx_t        wr_idx;
    logic        wr_en;

    // In IDLE the read can only be for a zero-wait request, which uses the live address.
    always_comb begin
        rd_addr = (state == S_IDLE) ? req_addr_i : addr_q;
        rd_idx  = idx_t'(addr_to_index(rd_addr, BASE_ADDR));
        rd_ok   = addr_ok(rd_addr, BASE_ADDR, DEPTH_W);
        wr_idx  = idx_t'(addr_to_index(load_addr_i, BASE_ADDR));
        wr_en   = load_we_i && addr_ok(load_addr_i, BASE_ADDR, DEPTH_W);
    end

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (wr_en),
        .wr_idx (wr_idx),
        .wr_data(load_data_i),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    // Fetch FSM with registered handshake outputs; response data is captured on RESP entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            rsp_valid_o <= 1'b0;
            rsp_inst_o  <= NOP_INST;
            rsp_err_o   <= 1'b0;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q      <= req_addr_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state       <= S_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= ~rd_ok;
                            rsp_inst_o  <= rd_ok ? rd_data : NOP_INST;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= ~rd_ok;
                        rsp_inst_o  <= rd_ok ? rd_data : NOP_INST;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    rsp_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_resp.sv
// Bench for inst_mem_resp: three instances (wait 1, 0, 3) sharing clock,
// reset and load port; table-driven fetches plus hand-written corner cases.
module tb_inst_mem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_inst  [3];
    logic        rsp_err   [3];
    logic        busy      [3];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic [31:0] addr;
        int          hold;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inst_mem_resp #(
            .DEPTH_WORDS(1024),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .BASE_ADDR  (32'h0000_0000),
            .NOP_INST   (32'h0000_0013)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_addr_i (req_addr[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g]),
            .rsp_inst_o (rsp_inst[g]),
            .rsp_err_o  (rsp_err[g]),
            .load_we_i  (load_we),
            .load_addr_i(load_addr),
            .load_data_i(load_data),
            .busy_o     (busy[g])
        );
    end

    function automatic int wc(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        load_we = 1'b1; load_addr = addr; load_data = data;
        @(posedge clk); #1;
        load_we = 1'b0;
    endtask

    // One complete fetch on instance d; optional same-edge write at RESP entry.
    task automatic fetch(input int d, input logic [31:0] addr, input int hold,
                         input logic coll, input logic [31:0] cdata,
                         input logic [31:0] einst, input logic eerr);
        exp_t e;
        int   n;
        check("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        rsp_ready[d] = (hold == 0);
        @(posedge clk); #1;
        sbq.push_back('{inst: einst, err: eerr});
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        check("busy_after_accept", {30'd0, busy[d], req_ready[d]}, 32'd2);
        if (coll) begin
            load_we = 1'b1; load_addr = addr; load_data = cdata;
        end
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            @(posedge clk); #1;
            load_we = 1'b0;
            n++;
        end
        load_we = 1'b0;
        check("latency", 32'(n), 32'(wc(d)));
        for (int i = 0; i < hold; i++) begin
            check("hold_valid", {30'd0, rsp_valid[d], req_ready[d]}, 32'd2);
            check("hold_inst", rsp_inst[d], einst);
            @(posedge clk); #1;
        end
        rsp_ready[d] = 1'b1;
        if (sbq.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check("rsp_inst", rsp_inst[d], e.inst);
            check("rsp_err", 32'(rsp_err[d]), 32'(e.err));
        end
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
        check("back_to_idle", {29'd0, rsp_valid[d], req_ready[d], busy[d]}, 32'd2);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{addr: 32'h0000_0000, hold: 0, inst: 32'h0050_0093, err: 1'b0};
        vecs[1] = '{addr: 32'h0000_0004, hold: 0, inst: 32'h00A0_0113, err: 1'b0};
        vecs[2] = '{addr: 32'h0000_0004, hold: 5, inst: 32'h00A0_0113, err: 1'b0};
        vecs[3] = '{addr: 32'h0000_0002, hold: 0, inst: 32'h0000_0013, err: 1'b1};
        vecs[4] = '{addr: 32'h0000_1000, hold: 0, inst: 32'h0000_0013, err: 1'b1};
        vecs[5] = '{addr: 32'h0000_0FFC, hold: 0, inst: 32'h1234_5678, err: 1'b0};
        vecs[6] = '{addr: 32'hFFFF_FFFC, hold: 2, inst: 32'h0000_0013, err: 1'b1};
        vecs[7] = '{addr: 32'h0000_0008, hold: 1, inst: 32'h0030_0193, err: 1'b0};
        vecs[8] = '{addr: 32'h0000_0005, hold: 0, inst: 32'h0000_0013, err: 1'b1};

        reset = 1'b1; load_we = 1'b0; load_addr = 32'd0; load_data = 32'd0;
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        check("reset_inst", rsp_inst[0], 32'h0000_0013);
        check("reset_flags", {28'd0, rsp_valid[0], rsp_err[0], req_ready[0], busy[0]}, 32'd2);

        load(32'h0000_0000, 32'h0050_0093);
        load(32'h0000_0004, 32'h00A0_0113);
        load(32'h0000_0008, 32'h0030_0193);
        load(32'h0000_0FFC, 32'h1234_5678);
        load(32'h0000_1000, 32'hBAD0_BAD0);
        load(32'h0000_0005, 32'hBAD1_BAD1);

        for (int i = 0; i < 9; i++) begin
            fetch(0, vecs[i].addr, vecs[i].hold, 1'b0, 32'd0, vecs[i].inst, vecs[i].err);
        end

        // Dropped writes must not have aliased onto words 0 and 1.
        fetch(0, 32'h0000_0000, 0, 1'b0, 32'd0, 32'h0050_0093, 1'b0);
        fetch(0, 32'h0000_0004, 0, 1'b0, 32'd0, 32'h00A0_0113, 1'b0);

        // Same-edge write at RESP entry: old word, then new word on refetch.
        fetch(0, 32'h0000_0008, 0, 1'b1, 32'hDEAD_BEEF, 32'h0030_0193, 1'b0);
        fetch(0, 32'h0000_0008, 0, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);

        // Zero-wait and three-wait instances.
        fetch(1, 32'h0000_0000, 0, 1'b0, 32'd0, 32'h0050_0093, 1'b0);
        fetch(2, 32'h0000_0004, 1, 1'b0, 32'd0, 32'h00A0_0113, 1'b0);
        fetch(2, 32'h0000_1004, 0, 1'b0, 32'd0, 32'h0000_0013, 1'b1);

        // Reset while the wait-3 instance sits in WAIT: outputs clear without a clock.
        req_valid[2] = 1'b1; req_addr[2] = 32'h0000_0000; rsp_ready[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        check("pre_reset_busy", 32'(busy[2]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset", {29'd0, rsp_valid[2], busy[2], req_ready[2]}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        rsp_ready[2] = 1'b0;
        @(posedge clk); #1;
        check("no_stale_rsp", 32'(rsp_valid[2]), 32'd0);
        fetch(2, 32'h0000_0000, 0, 1'b0, 32'd0, 32'h0050_0093, 1'b0);
        fetch(0, 32'h0000_0000, 0, 1'b0, 32'd0, 32'h0050_0093, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
